clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
//  Bank of NUM_CH independent programmable clock dividers/enable generators running off one clock.
//  Typical source is the single-ended board reference clock after the differential input buffer.
//  Each channel produces a registered square wave div_o and a one-cycle tick_o per output period.
//  Ratios are loaded at runtime through a valid/ready port and applied glitch-free at a period boundary.
//  sync_i re-phases all channels together.
// PARAMETERS
//  NUM_CH      4   number of divider channels (1..16)
//  DIV_WIDTH   16  width of the divide ratio N and of each channel counter
//  DEFAULT_DIV 2   ratio loaded into every channel at reset; 2 is the classic divide-by-two toggle
// PORTS
//  clk_ref    in   1                  single clock; every register is on posedge
//  sys_rst_i  in   1                  asynchronous, active-high reset
//  cfg_valid_i in  1                  ratio-write request
//  cfg_ready_o out 1                  write accepted when valid&&ready; combinational = !pend[cfg_ch_i]
//  cfg_ch_i   in   $clog2(NUM_CH)     target channel; values >= NUM_CH: ready=1, write dropped
//  cfg_div_i  in   DIV_WIDTH          new ratio N
//  sync_i     in   1                  one-cycle pulse: restart all counters in phase
//  div_o      out  NUM_CH             divided clock per channel (register, not clock-routed)
//  tick_o     out  NUM_CH             one-cycle pulse in the last cycle of each period
//  active_o   out  NUM_CH             1 when the channel ratio is >= 2
// BEHAVIOUR
//  Reset values (async assert; sync release in the clk_ref domain):
//   - cnt = 0; div = DEFAULT_DIV; pend = 0.
//   - div_o = 0, tick_o = 0, active_o = (DEFAULT_DIV >= 2) for all channels.
//  Per channel, with ratio N >= 2:
//   - cnt counts 0..N-1, then wraps to 0.
//   - div_o = (cnt >= N/2), integer division: low floor(N/2) cycles, high ceil(N/2) cycles.
//   - tick_o = (cnt == N-1).
//   - div_o and tick_o are flops, consistent with cnt in the same cycle (computed from next-state).
//   - Period is exactly N cycles; no skipped or extra cycle at wrap.
//  N = 0 or 1: channel off.
//   - cnt held at 0, div_o = 0, tick_o = 0, active_o = 0.
//  Config write (cfg_valid_i && cfg_ready_o):
//   - New ratio is stored in shadow register nxt[ch], and pend[ch] is set.
//   - Live ratio div[ch] is never written directly.
//  Apply: pend[ch] is transferred to div[ch] and pend is cleared on the first cycle with any of:
//   - cnt == N-1 (wrap)
//   - channel off
//   - sync_i = 1
//   On that cycle cnt becomes 0, and the new N governs from the next cycle on.
//  Glitch-free rule:
//   - A ratio change never truncates or stretches the current period.
//   - div_o changes only per the formulas above.
//  Write while pend[ch] = 1: cfg_ready_o = 0, request stalls (no overwrite, no drop).
//  Write and apply on the same channel in the same cycle: impossible by the ready rule.
//   - The apply uses the old nxt; ready rises the following cycle.
//  sync_i = 1:
//   - Every channel has cnt <= 0 and tick_o <= 0, then pend applies.
//   - An in-progress period is cut short deliberately; this is the only permitted truncation.
//  sync_i on the same cycle as a natural wrap: identical result (cnt = 0); no extra tick.
//  sys_rst_i mid-operation: immediate return to reset values; pending writes are lost.
// STRUCTURE
//  Package clk_div_pkg:
//   - typedef logic [DIV_WIDTH-1:0] div_t
//   - localparam DIV_OFF_MAX = 1
//   - function div_low_len(N) = N/2
//  Sub-module clk_div_channel, generated NUM_CH times:
//   - Contains cnt, div, nxt, pend, and the div_o/tick_o flops.
//   - Inputs: wr_en, wr_div, sync; outputs: pend, div_o, tick_o, active.
//  Top level: cfg_ch_i decode, cfg_ready_o mux, generate loop.
// TESTING
//  1. Reset, default N=2, run 8 cycles:
//     div_o[0] = 0,1,0,1,...; tick_o[0] on cycles 1,3,5,7; active_o = all 1.
//  2. Write ch1 N=5 during cnt=0:
//     current N=2 period completes; then div_o[1] low 2, high 3, period 5; tick_o[1] on cnt=4.
//  3. Write ch2 N=3, then ch2 N=7 the next cycle before apply:
//     second write stalls with cfg_ready_o = 0; after apply it is accepted;
//     one full N=3 period occurs before N=7.
//  4. Write ch3 N=0:
//     applies at ch3 wrap; div_o[3] = 0, tick_o[3] = 0, active_o[3] = 0;
//     then write N=4: applies next cycle, first tick on cycle 4.
//  5. Channels N = 2,3,4,5 free-running, pulse sync_i:
//     next cycle all cnt = 0, div_o = 0; ticks realign (coincident every 60 cycles).
//  6. Assert sys_rst_i mid-period with a pending write:
//     outputs at reset values asynchronously; after release N = DEFAULT_DIV and no pending.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the programmable clock-divider bank.
package clk_div_pkg;

  localparam int DEF_DIV_WIDTH = 16;
  localparam int DIV_OFF_MAX   = 1;

  typedef logic [DEF_DIV_WIDTH-1:0] div_t;

  // Number of low cycles in one output period of ratio n.
  function automatic logic [31:0] div_low_len(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: live ratio, shadow ratio with pending flag, period counter
// and registered div_o/tick_o derived from the next-state counter.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DIV_WIDTH-1:0] wr_div,
  input  logic                 sync,
  output logic                 pend,
  output logic                 div_o,
  output logic                 tick_o,
  output logic                 active
);

  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] OFF_MAX = DIV_WIDTH'(DIV_OFF_MAX);

  logic [DIV_WIDTH-1:0] cnt_reg;
  logic [DIV_WIDTH-1:0] cnt_next;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] div_next;
  logic [DIV_WIDTH-1:0] nxt_reg;
  logic [DIV_WIDTH-1:0] half_next;
  logic                 pend_reg;
  logic                 pend_next;
  logic                 div_o_reg;
  logic                 tick_o_reg;
  logic                 off;
  logic                 wrap;
  logic                 apply;
  logic                 on_next;

  always_comb begin
    off       = (div_reg <= OFF_MAX);
    wrap      = !off && (cnt_reg == div_reg - 1'b1);
    // A pending ratio only lands on a period boundary (or on sync / while off),
    // so the period in flight is never truncated or stretched.
    apply     = pend_reg && (wrap || off || sync);
    cnt_next  = (sync || off || wrap) ? '0 : cnt_reg + 1'b1;
    div_next  = apply ? nxt_reg : div_reg;
    on_next   = (div_next > OFF_MAX);
    half_next = DIV_WIDTH'(div_low_len(32'(div_next)));
    pend_next = apply ? 1'b0 : (pend_reg || wr_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      div_reg    <= DIV_RST;
      nxt_reg    <= DIV_RST;
      pend_reg   <= 1'b0;
      div_o_reg  <= 1'b0;
      tick_o_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      div_reg  <= div_next;
      pend_reg <= pend_next;
      if (wr_en && !pend_reg) begin
        nxt_reg <= wr_div;
      end
      // Outputs follow the counter value that holds during the next cycle.
      div_o_reg  <= on_next && (cnt_next >= half_next);
      tick_o_reg <= on_next && !sync && (cnt_next == div_next - 1'b1);
    end
  end

  assign pend   = pend_reg;
  assign div_o  = div_o_reg;
  assign tick_o = tick_o_reg;
  assign active = (div_reg > OFF_MAX);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers sharing one clock,
// with a valid/ready ratio-write port and a common re-phase pulse.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_ref,
  input  logic                 sys_rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CH_W-1:0]      cfg_ch_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 sync_i,
  output logic [NUM_CH-1:0]    div_o,
  output logic [NUM_CH-1:0]    tick_o,
  output logic [NUM_CH-1:0]    active_o
);

  logic [1:0]        rst_sync_reg;
  logic              core_rst;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr_en;

  // Reset asserts immediately and releases two clk_ref edges after sys_rst_i drops.
  always_ff @(posedge clk_ref or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      rst_sync_reg <= 2'b11;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b0};
    end
  end

  assign core_rst = rst_sync_reg[1];

  // Unmapped channel numbers report ready so the write is simply dropped.
  always_comb begin
    cfg_ready_o = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if ({1'b0, cfg_ch_i} == (CH_W + 1)'(i)) begin
        cfg_ready_o = !pend[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_en[gi] = cfg_valid_i && cfg_ready_o &&
                         ({1'b0, cfg_ch_i} == (CH_W + 1)'(gi));

      clk_div_channel #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk    (clk_ref),
        .rst    (core_rst),
        .wr_en  (wr_en[gi]),
        .wr_div (cfg_div_i),
        .sync   (sync_i),
        .pend   (pend[gi]),
        .div_o  (div_o[gi]),
        .tick_o (tick_o[gi]),
        .active (active_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: default ratio, runtime writes, stalls, off channels,
// sync re-phasing and mid-run reset.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  logic       clk_ref = 1'b0;
  logic       sys_rst_i;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [1:0] cfg_ch_i;
  div_t       cfg_div_i;
  logic       sync_i;
  logic [3:0] div_o;
  logic [3:0] tick_o;
  logic [3:0] active_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_ref = ~clk_ref;

  clk_div_bank #(
    .NUM_CH      (4),
    .DIV_WIDTH   (16),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_ref     (clk_ref),
    .sys_rst_i   (sys_rst_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_div_i   (cfg_div_i),
    .sync_i      (sync_i),
    .div_o       (div_o),
    .tick_o      (tick_o),
    .active_o    (active_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_ref);
    #1;
  endtask

  initial begin
    logic [4:0] d5;
    logic [4:0] t5;
    logic [6:0] d7;
    logic [6:0] t7;
    logic [4:0] d4;
    logic [4:0] t4;
    logic [3:0] ed;
    logic [3:0] et;

    d5 = 5'b11100; t5 = 5'b10000;
    d7 = 7'b1111000; t7 = 7'b1000000;
    d4 = 5'b01100; t4 = 5'b01000;

    sys_rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_ch_i = 2'd0; cfg_div_i = '0; sync_i = 1'b0;
    #2;
    chk("rst_div", div_o, 4'h0);
    chk("rst_tick", tick_o, 4'h0);
    chk("rst_active", active_o, 4'hF);
    chk("rst_ready", cfg_ready_o, 1'b1);
    cyc(); cyc();
    sys_rst_i = 1'b0;
    cyc(); cyc();
    chk("rel_div", div_o, 4'h0);
    chk("rel_tick", tick_o, 4'h0);

    // Test 1: default N=2 on every channel, c = 1..8
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("t1_div c%0d", i), div_o, (i % 2 == 1) ? 4'hF : 4'h0);
      chk($sformatf("t1_tick c%0d", i), tick_o, (i % 2 == 1) ? 4'hF : 4'h0);
    end
    chk("t1_active", active_o, 4'hF);

    // Test 2: ch1 N=5 written at c=8 (cnt=0)
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 16'd5;
    $display("cfg write ch1 N=5 at c=8");
    chk("t2_ready", cfg_ready_o, 1'b1);
    cyc();
    cfg_valid_i = 1'b0;
    chk("t2_pend_ready", cfg_ready_o, 1'b0);
    chk("t2_c9_div1", div_o[1], 1'b1);
    chk("t2_c9_tick1", tick_o[1], 1'b1);
    for (int c = 10; c <= 19; c++) begin
      cyc();
      chk($sformatf("t2_div1 c%0d", c), div_o[1], d5[(c - 10) % 5]);
      chk($sformatf("t2_tick1 c%0d", c), tick_o[1], t5[(c - 10) % 5]);
      chk($sformatf("t2_div0 c%0d", c), div_o[0], c % 2);
      if (c == 10) chk("t2_ready_back", cfg_ready_o, 1'b1);
    end

    // Test 3: ch2 N=3 at c=20, then N=7 stalls until the N=3 write applies
    cyc();
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd2; cfg_div_i = 16'd3;
    $display("cfg write ch2 N=3 at c=20");
    chk("t3_ready_first", cfg_ready_o, 1'b1);
    cyc();
    cfg_div_i = 16'd7;
    chk("t3_stall", cfg_ready_o, 1'b0);
    chk("t3_c21_div2", div_o[2], 1'b1);
    chk("t3_c21_tick2", tick_o[2], 1'b1);
    cyc();
    chk("t3_ready_after_apply", cfg_ready_o, 1'b1);
    chk("t3_c22_div2", div_o[2], 1'b0);
    chk("t3_c22_tick2", tick_o[2], 1'b0);
    cyc();
    cfg_valid_i = 1'b0;
    $display("cfg write ch2 N=7 accepted at c=22");
    chk("t3_pend7", cfg_ready_o, 1'b0);
    chk("t3_c23_div2", div_o[2], 1'b1);
    chk("t3_c23_tick2", tick_o[2], 1'b0);
    cyc();
    chk("t3_c24_div2", div_o[2], 1'b1);
    chk("t3_c24_tick2", tick_o[2], 1'b1);
    for (int p = 0; p < 7; p++) begin
      cyc();
      chk($sformatf("t3_div2 p%0d", p), div_o[2], d7[p]);
      chk($sformatf("t3_tick2 p%0d", p), tick_o[2], t7[p]);
    end

    // Test 4: ch3 N=0 at c=32, then N=4 at c=36
    cyc();
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd3; cfg_div_i = 16'd0;
    $display("cfg write ch3 N=0 at c=32");
    chk("t4_ready", cfg_ready_o, 1'b1);
    cyc();
    cfg_valid_i = 1'b0;
    chk("t4_c33_div3", div_o[3], 1'b1);
    chk("t4_c33_tick3", tick_o[3], 1'b1);
    chk("t4_c33_active3", active_o[3], 1'b1);
    for (int c = 34; c <= 35; c++) begin
      cyc();
      chk($sformatf("t4_off_div3 c%0d", c), div_o[3], 1'b0);
      chk($sformatf("t4_off_tick3 c%0d", c), tick_o[3], 1'b0);
      chk($sformatf("t4_off_active3 c%0d", c), active_o[3], 1'b0);
    end
    cyc();
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd3; cfg_div_i = 16'd4;
    $display("cfg write ch3 N=4 at c=36");
    chk("t4_ready_off", cfg_ready_o, 1'b1);
    cyc();
    cfg_valid_i = 1'b0;
    chk("t4_c37_active3", active_o[3], 1'b0);
    chk("t4_c37_div3", div_o[3], 1'b0);
    for (int p = 0; p < 5; p++) begin
      cyc();
      chk($sformatf("t4_div3 c%0d", 38 + p), div_o[3], d4[p]);
      chk($sformatf("t4_tick3 c%0d", 38 + p), tick_o[3], t4[p]);
      chk($sformatf("t4_active3 c%0d", 38 + p), active_o[3], 1'b1);
    end

    // Test 5: N = 2,3,4,5 on ch0..3, aligned by sync
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 16'd3;
    chk("t5_ready_ch1", cfg_ready_o, 1'b1);
    cyc();
    cfg_ch_i = 2'd2; cfg_div_i = 16'd4;
    chk("t5_ready_ch2", cfg_ready_o, 1'b1);
    cyc();
    cfg_ch_i = 2'd3; cfg_div_i = 16'd5;
    chk("t5_ready_ch3", cfg_ready_o, 1'b1);
    cyc();
    cfg_valid_i = 1'b0;
    sync_i = 1'b1;
    $display("cfg writes ch1..3 N=3,4,5, then sync pulse");
    cyc();
    sync_i = 1'b0;
    chk("t5_sync_div", div_o, 4'h0);
    chk("t5_sync_tick", tick_o, 4'h0);
    chk("t5_sync_active", active_o, 4'hF);
    for (int k = 1; k <= 62; k++) begin
      cyc();
      for (int ch = 0; ch < 4; ch++) begin
        ed[ch] = ((k % (ch + 2)) >= ((ch + 2) / 2));
        et[ch] = ((k % (ch + 2)) == (ch + 1));
      end
      chk($sformatf("t5_div k%0d", k), div_o, ed);
      chk($sformatf("t5_tick k%0d", k), tick_o, et);
      if (k == 59) chk("t5_coincident_tick", tick_o, 4'hF);
      if (k == 60) chk("t5_sync_on_wrap_tick", tick_o, 4'h0);
      if (k == 61) begin
        chk("t5_k61_tick", tick_o, 4'b0001);
        chk("t5_k61_div", div_o, 4'b0011);
      end
      sync_i = (k == 59);
    end
    sync_i = 1'b0;

    // Test 6: reset mid-period with a pending write on ch1
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 16'd9;
    $display("cfg write ch1 N=9, then reset");
    chk("t6_ready", cfg_ready_o, 1'b1);
    cyc();
    cfg_valid_i = 1'b0;
    chk("t6_pending", cfg_ready_o, 1'b0);
    #2;
    sys_rst_i = 1'b1;
    #1;
    chk("t6_async_div", div_o, 4'h0);
    chk("t6_async_tick", tick_o, 4'h0);
    chk("t6_async_active", active_o, 4'hF);
    chk("t6_async_ready", cfg_ready_o, 1'b1);
    cyc(); cyc();
    sys_rst_i = 1'b0;
    cyc(); cyc();
    chk("t6_rel_div", div_o, 4'h0);
    chk("t6_rel_ready", cfg_ready_o, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("t6_div c%0d", i), div_o, (i % 2 == 1) ? 4'hF : 4'h0);
      chk($sformatf("t6_tick c%0d", i), tick_o, (i % 2 == 1) ? 4'hF : 4'h0);
    end
    chk("t6_no_pend", cfg_ready_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
